// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state and requester id.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Port 0 is the instruction-fetch requester, port 1 the data requester.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the port that was not served last.
module rr_pick
  import mem_pkg::*;
(
  input  logic     req0_i,
  input  logic     req1_i,
  input  port_id_t last_i,
  output port_id_t grant_o
);

  always_comb begin
    grant_o = PORT0;
    if (req0_i && req1_i) begin
      grant_o = (last_i == PORT0) ? PORT1 : PORT0;
    end else if (req1_i) begin
      grant_o = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch (port 0) and data (port 1) requests onto a
// single memory-controller channel, one transaction at a time.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p0_r_en,
  input  logic                  p0_w_en,
  output logic                  p0_cplt,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_r_en,
  input  logic                  p1_w_en,
  output logic                  p1_cplt,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  input  logic                  mem_rdy,
  input  logic                  mem_cplt,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  state_t                state_q;
  port_id_t              port_q;
  port_id_t              last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rEn_q;
  logic                  wEn_q;

  logic                  p0Req;
  logic                  p1Req;
  port_id_t              grant;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic                  selRead;
  logic                  doneNow;

  assign p0Req = p0_r_en | p0_w_en;
  assign p1Req = p1_r_en | p1_w_en;

  rr_pick u_rr_pick (
    .req0_i (p0Req),
    .req1_i (p1Req),
    .last_i (last_q),
    .grant_o(grant)
  );

  // A port raising both enables is treated as a read.
  assign selAddr  = (grant == PORT0) ? p0_addr  : p1_addr;
  assign selWdata = (grant == PORT0) ? p0_wdata : p1_wdata;
  assign selRead  = (grant == PORT0) ? p0_r_en  : p1_r_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= PORT0;
      last_q  <= PORT1;
      addr_q  <= '0;
      wdata_q <= '0;
      rEn_q   <= 1'b0;
      wEn_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p0Req || p1Req) begin
            port_q  <= grant;
            last_q  <= grant;
            addr_q  <= selAddr;
            wdata_q <= selWdata;
            rEn_q   <= selRead;
            wEn_q   <= ~selRead;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rdy) begin
            rEn_q   <= 1'b0;
            wEn_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_cplt) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_r_en    = rEn_q;
  assign mem_w_en    = wEn_q;

  // Completion is passed straight through so the requester sees it in the same cycle.
  assign doneNow  = (state_q == WAIT) && mem_cplt;
  assign p0_cplt  = doneNow && (port_q == PORT0);
  assign p1_cplt  = doneNow && (port_q == PORT1);
  assign p0_rdata = p0_cplt ? mem_data_out : '0;
  assign p1_rdata = p1_cplt ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand-written sequences
// for stall, reset-in-WAIT and post-reset arbitration.
module tb_mem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [15:0] Z = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_r_en, p0_w_en, p1_r_en, p1_w_en;
  logic        p0_cplt, p1_cplt;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_r_en, mem_w_en, mem_rdy, mem_cplt;

  int assertCount = 0;
  int failCount   = 0;
  int issueCycles = 0;

  typedef struct {
    logic        p0r, p0w;
    logic [15:0] a0, w0;
    logic        p1r, p1w;
    logic [15:0] a1, w1;
    logic        rdy, mc;
    logic [15:0] mdo;
    logic        er, ew;
    logic [15:0] ea, ed;
    logic        ec0;
    logic [15:0] erd0;
    logic        ec1;
    logic [15:0] erd1;
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_r_en(p0_r_en), .p0_w_en(p0_w_en),
    .p0_cplt(p0_cplt), .p0_rdata(p0_rdata),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_r_en(p1_r_en), .p1_w_en(p1_w_en),
    .p1_cplt(p1_cplt), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .mem_rdy(mem_rdy), .mem_cplt(mem_cplt),
    .mem_data_out(mem_data_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    p0_r_en = v.p0r; p0_w_en = v.p0w; p0_addr = v.a0; p0_wdata = v.w0;
    p1_r_en = v.p1r; p1_w_en = v.p1w; p1_addr = v.a1; p1_wdata = v.w1;
    mem_rdy = v.rdy; mem_cplt = v.mc; mem_data_out = v.mdo;
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, ".mem_r_en"}, mem_r_en, L);
    checkBit({tag, ".mem_w_en"}, mem_w_en, L);
    checkOutput({tag, ".mem_addr"}, mem_addr, Z);
    checkOutput({tag, ".mem_data_in"}, mem_data_in, Z);
    checkBit({tag, ".p0_cplt"}, p0_cplt, L);
    checkBit({tag, ".p1_cplt"}, p1_cplt, L);
  endtask

  initial begin
    // Tie from reset goes to port 0, then port 1's pending write.
    vecs[0]  = '{H,L,16'h0010,Z, L,H,16'h0100,16'h1234, H,L,Z,           L,L,Z,Z,                   L,Z,L,Z};
    vecs[1]  = '{H,L,16'h0010,Z, L,H,16'h0100,16'h1234, H,L,Z,           H,L,16'h0010,Z,            L,Z,L,Z};
    vecs[2]  = '{H,L,16'h0010,Z, L,H,16'h0100,16'h1234, H,H,16'h5555,    L,L,16'h0010,Z,            H,16'h5555,L,Z};
    vecs[3]  = '{L,L,Z,Z,        L,H,16'h0100,16'h1234, H,L,Z,           L,L,16'h0010,Z,            L,Z,L,Z};
    vecs[4]  = '{L,L,Z,Z,        L,H,16'h0100,16'h1234, H,L,Z,           L,H,16'h0100,16'h1234,     L,Z,L,Z};
    vecs[5]  = '{L,L,Z,Z,        L,H,16'h0100,16'h1234, H,H,16'h7777,    L,L,16'h0100,16'h1234,     L,Z,H,16'h7777};
    // Lone port 0 read with completion three cycles after the issue cycle.
    vecs[6]  = '{H,L,16'h0040,Z, L,L,Z,Z,               H,L,Z,           L,L,16'h0100,16'h1234,     L,Z,L,Z};
    vecs[7]  = '{H,L,16'h0040,Z, L,L,Z,Z,               H,L,Z,           H,L,16'h0040,Z,            L,Z,L,Z};
    vecs[8]  = '{H,L,16'h0040,Z, L,L,Z,Z,               H,L,Z,           L,L,16'h0040,Z,            L,Z,L,Z};
    vecs[9]  = '{H,L,16'h0040,Z, L,L,Z,Z,               H,L,Z,           L,L,16'h0040,Z,            L,Z,L,Z};
    vecs[10] = '{H,L,16'h0040,Z, L,L,Z,Z,               H,H,16'hBEEF,    L,L,16'h0040,Z,            H,16'hBEEF,L,Z};
    // Spurious completion in IDLE, then a tie won by port 1 (read+write as read).
    vecs[11] = '{L,L,Z,Z,        L,L,Z,Z,               H,H,16'hDEAD,    L,L,16'h0040,Z,            L,Z,L,Z};
    vecs[12] = '{H,L,16'h0A0A,16'h1111, H,H,16'h0020,16'h2222, H,L,Z,    L,L,16'h0040,Z,            L,Z,L,Z};
    vecs[13] = '{H,L,16'h0A0A,16'h1111, H,H,16'h0020,16'h2222, H,L,Z,    H,L,16'h0020,16'h2222,     L,Z,L,Z};
    vecs[14] = '{H,L,16'h0A0A,16'h1111, H,H,16'h0020,16'h2222, H,H,16'h3333, L,L,16'h0020,16'h2222, L,Z,H,16'h3333};
    vecs[15] = '{H,L,16'h0A0A,16'h1111, L,L,Z,Z,        H,L,Z,           L,L,16'h0020,16'h2222,     L,Z,L,Z};
    vecs[16] = '{H,L,16'h0A0A,16'h1111, L,L,Z,Z,        H,L,Z,           H,L,16'h0A0A,16'h1111,     L,Z,L,Z};
    vecs[17] = '{H,L,16'h0A0A,16'h1111, L,L,Z,Z,        H,H,16'h4444,    L,L,16'h0A0A,16'h1111,     H,16'h4444,L,Z};
    vecs[18] = '{L,L,Z,Z,        L,L,Z,Z,               H,L,Z,           L,L,16'h0A0A,16'h1111,     L,Z,L,Z};
    vecs[19] = '{L,L,Z,Z,        L,L,Z,Z,               H,L,Z,           L,L,16'h0A0A,16'h1111,     L,Z,L,Z};

    rst = 1'b1;
    applyStimulus(vecs[19]);
    mem_rdy = 1'b0;
    #1;
    checkAllZero("reset");
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkBit($sformatf("v%0d.mem_r_en", i), mem_r_en, vecs[i].er);
      checkBit($sformatf("v%0d.mem_w_en", i), mem_w_en, vecs[i].ew);
      checkOutput($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].ea);
      checkOutput($sformatf("v%0d.mem_data_in", i), mem_data_in, vecs[i].ed);
      checkBit($sformatf("v%0d.p0_cplt", i), p0_cplt, vecs[i].ec0);
      checkOutput($sformatf("v%0d.p0_rdata", i), p0_rdata, vecs[i].erd0);
      checkBit($sformatf("v%0d.p1_cplt", i), p1_cplt, vecs[i].ec1);
      checkOutput($sformatf("v%0d.p1_rdata", i), p1_rdata, vecs[i].erd1);
      step();
    end

    // ISSUE stalled for five cycles, accepted on the sixth.
    p0_r_en = 1'b1; p0_addr = 16'h0300; p0_wdata = Z; mem_rdy = 1'b0; mem_cplt = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      checkBit($sformatf("stall%0d.mem_r_en", k), mem_r_en, H);
      checkOutput($sformatf("stall%0d.mem_addr", k), mem_addr, 16'h0300);
      if (mem_r_en) issueCycles++;
      step();
    end
    mem_rdy = 1'b1;
    #1;
    checkBit("stall_accept.mem_r_en", mem_r_en, H);
    if (mem_r_en) issueCycles++;
    step();
    checkBit("stall_wait.mem_r_en", mem_r_en, L);
    checkOutput("stall_wait.mem_addr", mem_addr, 16'h0300);
    mem_cplt = 1'b1; mem_data_out = 16'hC0DE;
    #1;
    checkBit("stall_done.p0_cplt", p0_cplt, H);
    checkOutput("stall_done.p0_rdata", p0_rdata, 16'hC0DE);
    checkBit("stall_done.p1_cplt", p1_cplt, L);
    step();
    p0_r_en = 1'b0; mem_cplt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (mem_r_en) issueCycles++;
      step();
    end
    checkOutput("stall.issue_cycles", 16'(issueCycles), 16'd6);

    // Reset while waiting on a write abandons it.
    p1_w_en = 1'b1; p1_addr = 16'h0500; p1_wdata = 16'hABCD;
    step();
    step();
    checkBit("rstwait.pre.mem_w_en", mem_w_en, L);
    checkOutput("rstwait.pre.mem_addr", mem_addr, 16'h0500);
    rst = 1'b1; p1_w_en = 1'b0;
    #1;
    checkAllZero("rstwait.in_reset");
    mem_cplt = 1'b1; mem_data_out = 16'h9999;
    #1;
    checkBit("rstwait.cplt_in_reset", p1_cplt, L);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkBit($sformatf("rstwait.after%0d.p1_cplt", k), p1_cplt, L);
      checkBit($sformatf("rstwait.after%0d.p0_cplt", k), p0_cplt, L);
      checkBit($sformatf("rstwait.after%0d.mem_w_en", k), mem_w_en, L);
      step();
    end

    // First tie after reset must go to port 0 again.
    mem_cplt = 1'b0;
    p0_r_en = 1'b1; p0_addr = 16'h0111;
    p1_r_en = 1'b1; p1_addr = 16'h0222;
    step();
    checkOutput("post_reset_tie.mem_addr", mem_addr, 16'h0111);
    checkBit("post_reset_tie.mem_r_en", mem_r_en, H);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width of all ports.
REQ-003 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have, per requester i in {0 (instruction fetch), 1 (data)}, inputs pi_addr [ADDR_WIDTH], pi_wdata [DATA_WIDTH], pi_r_en 1, pi_w_en 1, held stable by requester until pi_cplt.
REQ-006 SHALL have, per requester, outputs pi_cplt 1 (one-cycle completion pulse) and pi_rdata [DATA_WIDTH] (valid only while pi_cplt=1).
REQ-007 SHALL have downstream outputs mem_addr [ADDR_WIDTH], mem_data_in [DATA_WIDTH], mem_r_en 1, mem_w_en 1, feeding the memory controller.
REQ-008 SHALL have downstream inputs mem_rdy 1, mem_cplt 1, mem_data_out [DATA_WIDTH] from the memory controller.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-010 IDLE: if any port requests (r_en|w_en), SHALL select winner, register its addr, wdata, op and port id, go to ISSUE next cycle; else stay IDLE.
REQ-011 Arbitration SHALL be round-robin: single requester wins outright; on simultaneous requests, the port not served last wins; last-served pointer resets to port 1 (so port 0 wins first tie).
REQ-012 If one port asserts r_en and w_en together, SHALL treat it as a read; w_en ignored.
REQ-013 ISSUE: SHALL drive registered addr/wdata on mem_addr/mem_data_in and assert exactly one of mem_r_en/mem_w_en; on a cycle with mem_rdy=1, go to WAIT; mem_r_en/mem_w_en deassert in the following cycle.
REQ-014 ISSUE with mem_rdy=0 SHALL hold all downstream outputs unchanged indefinitely.
REQ-015 WAIT: mem_r_en=mem_w_en=0, mem_addr/mem_data_in held; on mem_cplt=1, SHALL combinationally assert p<granted>_cplt and pass mem_data_out to p<granted>_rdata in that same cycle, then go IDLE.
REQ-016 pi_cplt SHALL be asserted for writes as well as reads; non-granted port's cplt SHALL remain 0.
REQ-017 mem_cplt outside WAIT SHALL be ignored.
REQ-018 Minimum request-to-issue latency SHALL be 1 cycle; request-to-cplt = 1 + ISSUE stall + downstream latency.
REQ-019 Requester deasserts its enables the cycle after its cplt; the arbiter SHALL rely on this, with no extra blocking of the served port.
REQ-020 Requests arriving during ISSUE/WAIT SHALL not be dropped; they are serviced from IDLE (level-sensitive enables).
REQ-021 pi_rdata SHALL be 0 when pi_cplt=0.

Reset
REQ-022 On rst: state IDLE, mem_r_en=mem_w_en=0, mem_addr=0, mem_data_in=0, p0_cplt=p1_cplt=0, last-served=1.
REQ-023 Reset mid-ISSUE/WAIT SHALL abandon the transaction; no cplt issued for it.

Structure
REQ-024 State enum (IDLE/ISSUE/WAIT) and port id type SHALL live in shared package mem_pkg.
REQ-025 Round-robin selection SHALL be sub-module rr_pick (two request inputs, last-served input, grant output), combinational.

Verification
REQ-026 p0 read addr 0x0040, mem_rdy=1, mem_cplt 3 cycles after issue with data 0xBEEF -> mem_r_en high exactly 1 cycle, p0_cplt 1-cycle pulse, p0_rdata=0xBEEF, p1_cplt=0.
REQ-027 p0 read 0x0010 and p1 write 0x0100/0x1234 same cycle -> p0 issued first, then p1 write with mem_data_in=0x1234; next tie -> p1 first.
REQ-028 mem_rdy=0 for 5 cycles in ISSUE -> mem_r_en/mem_addr stable 5 cycles, issue accepted cycle 6, single transaction only.
REQ-029 rst asserted in WAIT -> all outputs 0 immediately, later mem_cplt produces no pi_cplt.
REQ-030 p1 asserts r_en and w_en at 0x0020 -> mem_r_en=1, mem_w_en=0.
REQ-031 spurious mem_cplt in IDLE -> no pi_cplt, state remains IDLE.
